// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int          DIV_WIDTH     = 32;
    // Edges from the accepting start edge to the edge that raises done.
    localparam int          DIV_LATENCY   = 33;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Latency: 0 (pure comb); backpressure: none.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // The shifted remainder needs WIDTH+1 bits when the divisor magnitude is 2^(WIDTH-1).
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_dvs});
    assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;
    assign o_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_divider.sv
// Signed restoring divider with start/busy/done handshake; fixed 33-edge latency start->done.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;
    logic             r_div_by_zero;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_dd_mag;
    logic [WIDTH-1:0] w_dv_mag;
    logic             w_last;

    // Negating the most negative value yields 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_dd_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign w_dv_mag = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = ITER;
            ITER:    if (w_last)  w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == ITER) || (r_state == FIX);
        o_done = (r_state == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_cnt         <= '0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_dz          <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_rem    <= '0;
                        r_quo    <= w_dd_mag;
                        r_dvs    <= w_dv_mag;
                        r_cnt    <= '0;
                        r_sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                        r_sign_r <= i_dividend[WIDTH-1];
                        r_dz     <= (i_divisor == '0);
                    end
                end
                ITER: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    // A zero divisor reports all-ones regardless of dividend sign.
                    r_quotient    <= r_dz ? '1 : (r_sign_q ? -r_quo : r_quo);
                    r_remainder   <= r_sign_r ? -r_rem : r_rem;
                    r_div_by_zero <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors, latency and handshake checks.
module tb_seq_divider;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dd = '0;
    logic [31:0] dv = '0;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        dz;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          e0;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    seq_divider dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_dividend    (dd),
        .i_divisor     (dv),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quot),
        .o_remainder   (rem),
        .o_div_by_zero (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 want no done (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient",     quot,               e.q);
                check("remainder",    rem,                e.r);
                check("div_by_zero",  32'(dz),            32'(e.dz));
                check("latency",      32'(cyc - e.e0),    32'(DIV_LATENCY));
                check("busy_at_done", 32'(busy),          32'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input bit push);
        dd    = a;
        dv    = b;
        start = 1'b1;
        if (push) sb.push_back('{eq, er, edz, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Waits for the scoreboard to drain, then one more edge so the DUT is back in IDLE.
    task automatic wait_done();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        check("done_seen", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    logic [31:0] t_dd [6] = '{32'd100, 32'hFFFF_FF9C, 32'd100,      32'd12, 32'h8000_0000, 32'd55};
    logic [31:0] t_dv [6] = '{32'd7,   32'd7,         32'hFFFF_FFF9, 32'd15, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_q  [6] = '{32'd14,  32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd0,  32'h8000_0000, DIV_ZERO_QUOT};
    logic [31:0] t_r  [6] = '{32'd2,   32'hFFFF_FFFE, 32'd2,         32'd12, 32'd0,         32'd55};
    logic        t_z  [6] = '{1'b0,    1'b0,          1'b0,          1'b0,   1'b0,          1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", quot,      32'd0);
        check("rst_rem",  rem,       32'd0);
        check("rst_dz",   32'(dz),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            issue(t_dd[i], t_dv[i], t_q[i], t_r[i], t_z[i], 1'b1);
            wait_done();
        end

        // start held high: accepted once, ignored in DONE, re-accepted on return to IDLE
        dd    = 32'd100;
        dv    = 32'd7;
        start = 1'b1;
        sb.push_back('{32'd14, 32'd2, 1'b0, cyc + 1});
        @(negedge clk);
        check("busy_held_start", 32'(busy), 32'd1);
        wait_done();
        check("busy_start_in_done", 32'(busy), 32'd0);
        sb.push_back('{32'd14, 32'd2, 1'b0, cyc + 1});
        @(negedge clk);
        check("busy_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done();

        // start and operand change mid-operation are ignored
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        dd    = 32'd9;
        dv    = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Clear mid-operation aborts with all outputs zero and no done
        issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quot", quot,      32'd0);
        check("abort_rem",  rem,       32'd0);
        check("abort_dz",   32'(dz),   32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        wait_done();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed 32-bit restoring divider that sits behind the ALU's DIV select and answers the control unit's DIV request.
- Dividend comes from the Y register and divisor from the bus.
- The result is written to the Z pair:
  - remainder → Zhi (moved to HI);
  - quotient → Zlow (moved to LO).
- A start/busy/done handshake lets the control sequencer hold in its DIV step until the result is valid, instead of assuming single-cycle completion.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Clear  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- dividend  in  WIDTH  signed two's complement, from Y.
- divisor  in  WIDTH  signed two's complement, from bus.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse; quotient/remainder valid from this cycle on.
- quotient  out  WIDTH  signed quotient, feeds Zlow.
- remainder  out  WIDTH  signed remainder, feeds Zhi.
- div_by_zero  out  1  set with done when divisor was 0; holds until next done.

Behaviour:
- Reset (Clear=0, async):
  - state=IDLE;
  - busy, done, div_by_zero, quotient, remainder, all internal registers = 0.
- States: IDLE, ITER, FIX, DONE; 2-bit encoding.
- IDLE:
  - start=1 at edge E0 → ITER, busy=1.
  - Capture |dividend|, |divisor|, sign_q = dividend[31]^divisor[31], sign_r = dividend[31], dz = (divisor==0).
  - Partial remainder cleared; counter = 0.
- ITER, one restoring step per edge:
  - shift {rem, quo} left 1;
  - trial = rem − |divisor|;
  - if trial ≥ 0 (no borrow, compare at WIDTH+1 bits): rem = trial, quo[0] = 1.
  - Exactly WIDTH steps on edges E1..E32; counter reaching WIDTH−1 at E32 → FIX.
- FIX, edge E33:
  - quotient = sign_q ? −quo : quo;
  - remainder = sign_r ? −rem : rem;
  - div_by_zero = dz; done=1; busy=0; → DONE.
- DONE, edge E34: done=0 → IDLE.
- Fixed latency: done is high in the cycle after E33 for every operand pair, including divide-by-zero. No early exit.
- Rounding: truncation toward zero; remainder carries the sign of the dividend; |remainder| < |divisor|.
- Divide by zero:
  - quotient = 32'hFFFFFFFF;
  - remainder = dividend unchanged (this falls out of the algorithm with sign fix);
  - div_by_zero=1.
- Overflow: −2^31 / −1 → quotient 32'h80000000, remainder 0. Unsigned magnitude arithmetic must handle the |−2^31| = 32'h80000000 case.
- start while busy or in DONE: ignored, with no effect on the running operation.
- dividend/divisor changes after E0: ignored; operands are latched.
- quotient/remainder/div_by_zero hold their values from FIX until the next FIX or reset.
- Clear asserted mid-operation: immediate abort, all outputs 0, no done pulse. Next start after release begins cleanly.
- Back-to-back: earliest next accepted start is at E35 (IDLE again).

Decomposition:
- Shared package div_pkg:
  - state encodings IDLE/ITER/FIX/DONE;
  - DIV_WIDTH = 32;
  - DIV_LATENCY = 33 (edges from accepted start to done);
  - DIV_ZERO_QUOT = 32'hFFFFFFFF.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: rem, quo, magnitude divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in ITER.
- Sign/magnitude and negate logic stays in seq_divider.

Test Plan:
- Identical operands across two runs confirm fixed latency; start held high through DONE is not re-accepted until IDLE.
- dividend=100, divisor=7, start pulse → done 33 edges later, quotient=14, remainder=2, div_by_zero=0, busy high E0..E32.
- dividend=−100, divisor=7 → quotient=32'hFFFFFFF2 (−14), remainder=32'hFFFFFFFE (−2); dividend=100, divisor=−7 → quotient=−14, remainder=2.
- dividend=12, divisor=15 → quotient=0, remainder=12; dividend=−2^31, divisor=−1 → quotient=32'h80000000, remainder=0.
- dividend=55, divisor=0 → quotient=32'hFFFFFFFF, remainder=55, div_by_zero=1 with done at the same latency; next valid division clears the flag.
- Start with 100/7; at E10, pulse start with 9/3 and change operands → ignored, result 14/2. At E20 of a second run, drop Clear → outputs 0 immediately, no done. After release, 9/3 → quotient=3, remainder=0.
